lsu_subword: RTL and testbench

// - Load/store unit between the datapath and the word-wide data memory; adds byte/halfword access.
// - Loads are sign- or zero-extended. Sub-word stores use a multi-cycle read-modify-write.
// - Flags misaligned accesses and never writes memory for them.
// - Drives the memory's addr/we/wdata and consumes its rdata. Memory read is asynchronous; memory write happens on posedge clk.

---
 rtl/lsu_subword.sv | 230 +++++++++++++++++++++++
 tb/tb_lsu_subword.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword.sv
// ============================================================================
// Module   : lsu_subword
// Purpose  : Load/store unit adding byte/halfword access over a word memory
//            (read-modify-write for sub-word stores). Optional statistics
//            counters are enabled with the LSU_STATS_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_subword #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [STAT_W-1:0] stat_loads,
  output logic [STAT_W-1:0] stat_stores,
  output logic [STAT_W-1:0] stat_errs
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD   = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [15:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        req_err;
  logic [4:0]  lane_sh;
  logic [31:0] shifted;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  always_comb begin
    req_err = (req_size == 2'b11)
            | ((req_size == 2'b01) & req_addr[0])
            | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
  end

  // Lane selection shared by load extraction and store merging.
  always_comb begin
    lane_sh = {addr_lo_q, 3'b000};
    shifted = mem_rdata >> lane_sh;
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   ld_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: ld_ext = mem_rdata;
    endcase
    if (size_q == 2'b00) begin
      merged = (mem_rdata & ~(32'h0000_00FF << lane_sh))
             | ({24'd0, wdata_q[7:0]} << lane_sh);
    end else begin
      merged = (mem_rdata & ~(32'h0000_FFFF << lane_sh))
             | ({16'd0, wdata_q} << lane_sh);
    end
  end

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_lo_d    = addr_lo_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d       = req_size;
          uns_d        = req_unsigned;
          addr_lo_d    = req_addr[1:0];
          wdata_d      = req_wdata[15:0];
          resp_err_d   = req_err;
          resp_rdata_d = 32'd0;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (!req_we) begin
              state_d = LD;
            end else if (req_size == 2'b10) begin
              state_d     = WR;
              mem_wdata_d = req_wdata;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      LD: begin
        resp_rdata_d = ld_ext;
        mem_addr_d   = 32'd0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      // The merged word doubles as the read-modify-write buffer.
      RD: begin
        mem_wdata_d = merged;
        state_d     = WR;
      end
      WR: begin
        mem_addr_d   = 32'd0;
        mem_wdata_d  = 32'd0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        state_d      = IDLE;
      end
      default: begin
        mem_addr_d  = 32'd0;
        mem_wdata_d = 32'd0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_lo_q    <= 2'b00;
      wdata_q      <= 16'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_lo_q    <= addr_lo_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = (state_q == WR) & ~rst;

`ifdef LSU_STATS_EN
  logic              we_q, we_d;
  logic [STAT_W-1:0] loads_q, loads_d;
  logic [STAT_W-1:0] stores_q, stores_d;
  logic [STAT_W-1:0] errs_q, errs_d;

  always_comb begin
    we_d     = (state_q == IDLE && req_valid) ? req_we : we_q;
    loads_d  = loads_q;
    stores_d = stores_q;
    errs_d   = errs_q;
    if (state_q == RESP) begin
      if (resp_err_q) begin
        if (errs_q != {STAT_W{1'b1}}) errs_d = errs_q + 1'b1;
      end else if (we_q) begin
        if (stores_q != {STAT_W{1'b1}}) stores_d = stores_q + 1'b1;
      end else begin
        if (loads_q != {STAT_W{1'b1}}) loads_d = loads_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else begin
      we_q     <= we_d;
      loads_q  <= loads_d;
      stores_q <= stores_d;
      errs_q   <= errs_d;
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errs   = errs_q;
`else
  assign stat_loads  = '0;
  assign stat_stores = '0;
  assign stat_errs   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_subword.sv
// ============================================================================
// Module   : tb_lsu_subword
// Purpose  : Directed self-checking bench for lsu_subword with a word memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_subword;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [1:0]  stat_loads, stat_stores, stat_errs;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:3];
  logic        ld_en;
  logic [1:0]  ld_idx;
  logic [31:0] ld_val;

  always #5 clk = ~clk;

  lsu_subword #(.STAT_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
  );

  assign mem_rdata = mem[mem_addr[3:2]];

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (mem_we) mem[mem_addr[3:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [1:0] idx, input logic [31:0] val);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = idx; ld_val = val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Issues one request and observes it until resp_valid (bounded).
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int nwe, output logic [31:0] wd,
                         output logic [31:0] rd, output logic err,
                         output logic [31:0] a1, output logic rdy1);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; nwe = 0; wd = 32'd0; rd = 32'hX; err = 1'bX;
    a1 = mem_addr; rdy1 = req_ready;
    for (int i = 1; i <= 8; i++) begin
      if (mem_we) begin
        nwe++;
        wd = mem_wdata;
      end
      if (resp_valid) begin
        lat = i; rd = resp_rdata; err = resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  int          lat, nwe;
  logic [31:0] wd, rd, a1;
  logic        err, rdy1;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    ld_en = 1'b1; ld_idx = 2'd0; ld_val = 32'h8899AABB;
    @(negedge clk);
    ld_idx = 2'd1; ld_val = 32'd0;
    @(negedge clk);
    ld_idx = 2'd2;
    @(negedge clk);
    ld_idx = 2'd3;
    @(negedge clk);
    ld_en = 1'b0;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_stats", {26'd0, stat_loads, stat_stores, stat_errs}, 32'd0);
    rst = 1'b0;

    // T1: word store then word load
    run_req(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, lat, nwe, wd, rd, err, a1, rdy1);
    chk("sw_lat", lat, 2);
    chk("sw_nwe", nwe, 1);
    chk("sw_wdata", wd, 32'hDEADBEEF);
    chk("sw_err", {31'd0, err}, 32'd0);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_busy", {31'd0, rdy1}, 32'd0);
    chk("sw_addr", a1, 32'h4);
    chk("sw_mem1", mem[1], 32'hDEADBEEF);
    chk("sw_mem0", mem[0], 32'h8899AABB);
    run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, nwe, wd, rd, err, a1, rdy1);
    chk("lw_lat", lat, 2);
    chk("lw_nwe", nwe, 0);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_addr", a1, 32'h4);
    @(negedge clk);
    chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    chk("resp_rdata_clr", resp_rdata, 32'd0);

    // T2: sub-word read-modify-write stores
    run_req(1'b1, 2'b00, 1'b0, 32'h1, 32'h000000CC, lat, nwe, wd, rd, err, a1, rdy1);
    chk("sb_lat", lat, 3);
    chk("sb_nwe", nwe, 1);
    chk("sb_wdata", wd, 32'h8899CCBB);
    chk("sb_addr", a1, 32'h0);
    chk("sb_mem0", mem[0], 32'h8899CCBB);
    run_req(1'b1, 2'b01, 1'b0, 32'h2, 32'hFFFF1234, lat, nwe, wd, rd, err, a1, rdy1);
    chk("sh_lat", lat, 3);
    chk("sh_wdata", wd, 32'h1234CCBB);
    chk("sh_mem0", mem[0], 32'h1234CCBB);

    // T3: load extension
    poke(2'd0, 32'h80FF7F01);
    run_req(1'b0, 2'b00, 1'b0, 32'h2, 32'h0, lat, nwe, wd, rd, err, a1, rdy1);
    chk("lb2", rd, 32'hFFFFFFFF);
    chk("lb2_lat", lat, 2);
    run_req(1'b0, 2'b00, 1'b1, 32'h2, 32'h0, lat, nwe, wd, rd, err, a1, rdy1);
    chk("lbu2", rd, 32'h000000FF);
    run_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, lat, nwe, wd, rd, err, a1, rdy1);
    chk("lh2", rd, 32'hFFFF80FF);
    run_req(1'b0, 2'b01, 1'b1, 32'h0, 32'h0, lat, nwe, wd, rd, err, a1, rdy1);
    chk("lhu0", rd, 32'h00007F01);
    run_req(1'b0, 2'b00, 1'b0, 32'h1, 32'h0, lat, nwe, wd, rd, err, a1, rdy1);
    chk("lb1", rd, 32'h0000007F);
    run_req(1'b0, 2'b10, 1'b1, 32'h0, 32'h0, lat, nwe, wd, rd, err, a1, rdy1);
    chk("lwu0", rd, 32'h80FF7F01);

    // T4: misaligned and illegal-size stores
    run_req(1'b1, 2'b01, 1'b0, 32'h3, 32'hFFFFFFFF, lat, nwe, wd, rd, err, a1, rdy1);
    chk("eh_lat", lat, 1);
    chk("eh_err", {31'd0, err}, 32'd1);
    chk("eh_nwe", nwe, 0);
    chk("eh_rdata", rd, 32'd0);
    chk("eh_addr", a1, 32'd0);
    run_req(1'b1, 2'b10, 1'b0, 32'h6, 32'hFFFFFFFF, lat, nwe, wd, rd, err, a1, rdy1);
    chk("ew_lat", lat, 1);
    chk("ew_err", {31'd0, err}, 32'd1);
    chk("ew_nwe", nwe, 0);
    run_req(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF, lat, nwe, wd, rd, err, a1, rdy1);
    chk("es_lat", lat, 1);
    chk("es_err", {31'd0, err}, 32'd1);
    chk("es_nwe", nwe, 0);
    chk("e_mem0", mem[0], 32'h80FF7F01);
    chk("e_mem1", mem[1], 32'hDEADBEEF);
    run_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, nwe, wd, rd, err, a1, rdy1);
    chk("post_err_ok", {31'd0, err}, 32'd0);

    // T5: reset during the WR cycle of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t5_rd_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    chk("t5_wr_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_ready", {31'd0, req_ready}, 32'd1);
    chk("t5_addr", mem_addr, 32'd0);
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) lat++;
      @(negedge clk);
    end
    chk("t5_no_resp", lat, 0);
    chk("t5_mem0", mem[0], 32'h80FF7F01);

    // T6: statistics counters
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, nwe, wd, rd, err, a1, rdy1);
    end
    run_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h00000001, lat, nwe, wd, rd, err, a1, rdy1);
    run_req(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, lat, nwe, wd, rd, err, a1, rdy1);
    @(negedge clk);
    chk("t6_mem2", mem[2], 32'h00000001);
`ifdef LSU_STATS_EN
    chk("stat_loads", {30'd0, stat_loads}, 32'd3);
    chk("stat_stores", {30'd0, stat_stores}, 32'd1);
    chk("stat_errs", {30'd0, stat_errs}, 32'd1);
`else
    chk("stat_loads", {30'd0, stat_loads}, 32'd0);
    chk("stat_stores", {30'd0, stat_stores}, 32'd0);
    chk("stat_errs", {30'd0, stat_errs}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
